// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the byte-stream program loader.
// State codes are plain localparams so legacy tools can compare them directly.
package prog_loader_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int INSTR_W_DEF     = 12;
    localparam int BYTES_PER_INSTR = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_LEN  = 3'd1;
    localparam state_t S_LO   = 3'd2;
    localparam state_t S_HI   = 3'd3;
    localparam state_t S_WR   = 3'd4;
    localparam state_t S_CHK  = 3'd5;
    localparam state_t S_DONE = 3'd6;

    // States in which the loader takes a byte from the stream.
    function automatic logic accepts_byte(input state_t s);
        return (s == S_LEN) || (s == S_LO) || (s == S_HI) || (s == S_CHK);
    endfunction

    function automatic logic [8*BYTES_PER_INSTR-1:0] pack_instr(input logic [7:0] lo,
                                                                input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives N, LO/HI instruction bytes and a checksum; writes program memory.
// Latency: one LE pulse per instruction, three cycles per instruction at full input rate.
// Backpressure: in_ready is a registered state decode; input gaps stall indefinitely.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          INSTR_W   = INSTR_W_DEF,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               LE,
    output logic [ADDR_W-1:0]  LA,
    output logic [INSTR_W-1:0] LI,
    output logic               busy,
    output logic               core_hold,
    output logic               done,
    output logic               err
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     cnt;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          sum;
    logic [7:0]          lo;
    logic                xfer;

    assign xfer      = in_valid & in_ready;
    assign core_hold = busy;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LEN;
            S_LEN:          if (xfer)  state_nxt = S_LO;
            S_LO:           if (xfer)  state_nxt = S_HI;
            S_HI:           if (xfer)  state_nxt = S_WR;
            S_WR:           state_nxt = (cnt == CNT_ONE) ? S_CHK : S_LO;
            S_CHK:          if (xfer)  state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            LE       <= 1'b0;
            LA       <= BASE;
            LI       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
            addr     <= BASE;
            sum      <= '0;
            lo       <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= accepts_byte(state_nxt);
            LE       <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done <= 1'b0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                        addr <= BASE;
                        sum  <= '0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        cnt <= (in_data == 8'd0) ? CNT_MAX : (ADDR_W+1)'(in_data);
                        sum <= sum + in_data;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        lo  <= in_data;
                        sum <= sum + in_data;
                    end
                end
                S_HI: begin
                    // The write is staged here so LE/LA/LI are registered during WR.
                    if (xfer) begin
                        sum <= sum + in_data;
                        LE  <= 1'b1;
                        LA  <= addr;
                        LI  <= INSTR_W'(pack_instr(lo, in_data));
                    end
                end
                S_WR: begin
                    addr <= addr + 1'b1;
                    cnt  <= cnt - 1'b1;
                end
                S_CHK: begin
                    if (xfer) begin
                        err  <= (in_data != sum);
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as bytes are driven
// and popped whenever LE is seen.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        LE;
    logic [7:0]  LA;
    logic [11:0] LI;
    logic        busy;
    logic        core_hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .INSTR_W(12), .BASE_ADDR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .LE        (LE),
        .LA        (LA),
        .LI        (LI),
        .busy      (busy),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [7:0]  a;
        logic [11:0] i;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] wbuf[256];
    logic [7:0]  exp_addr;
    int          n_pass   = 0;
    int          n_total  = 0;
    int          overlap  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (LE && in_ready) overlap++;
        if (LE) begin
            if (sb.size() == 0) begin
                check("le_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_la", 32'(LA), 32'(e.a));
                check("wr_li", 32'(LI), 32'(e.i));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_start();
        exp_addr = 8'd0;
        pulse_start();
        check("start_done",  32'(done), 0);
        check("start_err",   32'(err), 0);
        check("start_busy",  32'(busy), 1);
        check("start_hold",  32'(core_hold), 1);
        check("start_rdy",   32'(in_ready), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) begin
            for (int k = 0; k < 4 && $urandom_range(1, 0) == 1; k++) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("byte_timeout", 0, 1);
    endtask

    task automatic push_word(input logic [15:0] w);
        wr_t e;
        e.a = exp_addr;
        e.i = w[11:0];
        sb.push_back(e);
        exp_addr = exp_addr + 8'd1;
    endtask

    // n = 1..256 instructions taken from wbuf; a bad frame sends CHK=0x00.
    task automatic send_frame(input int n, input bit bad, input bit gaps, input bit poke);
        logic [7:0]  sum;
        logic [7:0]  nb;
        logic [15:0] w;
        nb  = 8'(n);
        sum = nb;
        send_byte(nb, gaps);
        for (int i = 0; i < n; i++) begin
            w = wbuf[i];
            push_word(w);
            send_byte(w[7:0], gaps);
            if (poke && i == 1) pulse_start();
            send_byte(w[15:8], gaps);
            sum = sum + w[7:0] + w[15:8];
        end
        send_byte(bad ? 8'h00 : sum, gaps);
    endtask

    task automatic check_end(input string tag, input bit bad);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_err"},  32'(err), 32'(bad));
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_hold"}, 32'(core_hold), 0);
        check({tag, "_rdy"},  32'(in_ready), 0);
        check({tag, "_sb"},   sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_le"},   32'(LE), 0);
        check({tag, "_la"},   32'(LA), 0);
        check({tag, "_li"},   32'(LI), 0);
        check({tag, "_rdy"},  32'(in_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_hold"}, 32'(core_hold), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"},  32'(err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_addr = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // start together with rst: reset wins
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        check("rst_start_busy", 32'(busy), 0);

        // Good N=3 frame, in_valid held high
        wbuf[0] = 16'h0123; wbuf[1] = 16'h0ABC; wbuf[2] = 16'h000F;
        do_start();
        send_frame(3, 1'b0, 1'b0, 1'b0);
        check_end("good", 1'b0);

        // Same frame with a wrong checksum
        do_start();
        send_frame(3, 1'b1, 1'b0, 1'b0);
        check_end("bad", 1'b1);

        // start in DONE clears flags; random gaps plus an ignored start mid-load
        do_start();
        send_frame(3, 1'b0, 1'b1, 1'b1);
        check_end("gaps", 1'b0);

        // N=0 means 256 instructions; address wraps after 255
        for (int i = 0; i < 256; i++) wbuf[i] = 16'(i);
        do_start();
        send_frame(256, 1'b0, 1'b0, 1'b0);
        check_end("n256", 1'b0);
        check("n256_la_last", 32'(LA), 255);
        check("n256_li_last", 32'(LI), 255);

        // Reset after the second write of an N=5 load
        do_start();
        send_byte(8'd5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            w = 16'h0111 * 16'(i + 1);
            push_word(w);
            send_byte(w[7:0], 1'b0);
            send_byte(w[15:8], 1'b0);
        end
        check("mid_le", 32'(LE), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        check("midrst_sb", sb.size(), 0);

        wbuf[0] = 16'h05A5;
        do_start();
        send_frame(1, 1'b0, 1'b0, 1'b0);
        check_end("fresh", 1'b0);
        check("fresh_la", 32'(LA), 0);

        check("le_rdy_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
